// File: rtl/uart_alu_sequencer.sv
// Command sequencer between the UART and the ALU: gathers operand A, operand B and
// opcode bytes, runs the ALU for one cycle and hands the result to the UART TX.
module uart_alu_sequencer #(
  parameter int NB_DATA    = 8,
  parameter int NB_OP      = 6,
  parameter int NB_TIMEOUT = 16,
  parameter int TIMEOUT    = 50000
) (
  input  logic               clk,
  input  logic               i_reset,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_rx_done,
  input  logic [NB_DATA-1:0] i_alu_result,
  input  logic               i_tx_done,
  output logic [NB_DATA-1:0] o_alu_a,
  output logic [NB_DATA-1:0] o_alu_b,
  output logic [NB_OP-1:0]   o_alu_op,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_tx_start,
  output logic               o_busy,
  output logic               o_timeout,
  output logic               o_overrun
);

  typedef enum logic [2:0] {
    WAIT_A,
    WAIT_B,
    WAIT_OP,
    EXEC,
    SEND,
    WAIT_TX
  } state_t;

  localparam logic [NB_TIMEOUT-1:0] TIMEOUT_LAST = NB_TIMEOUT'(TIMEOUT - 1);

  state_t                r_state;
  logic [NB_TIMEOUT-1:0] r_count;
  logic                  w_expired;

  assign w_expired = (r_count == TIMEOUT_LAST);

  // A received byte always wins over a timeout expiring on the same cycle.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      r_state    <= WAIT_A;
      r_count    <= '0;
      o_alu_a    <= '0;
      o_alu_b    <= '0;
      o_alu_op   <= '0;
      o_tx_data  <= '0;
      o_tx_start <= 1'b0;
      o_busy     <= 1'b0;
      o_timeout  <= 1'b0;
      o_overrun  <= 1'b0;
    end else begin
      o_tx_start <= 1'b0;
      o_timeout  <= 1'b0;
      o_overrun  <= 1'b0;
      case (r_state)
        WAIT_A: begin
          if (i_rx_done) begin
            o_alu_a <= i_rx_data;
            r_count <= '0;
            r_state <= WAIT_B;
            o_busy  <= 1'b1;
          end
        end
        WAIT_B: begin
          if (i_rx_done) begin
            o_alu_b <= i_rx_data;
            r_count <= '0;
            r_state <= WAIT_OP;
          end else if (w_expired) begin
            o_timeout <= 1'b1;
            r_count   <= '0;
            r_state   <= WAIT_A;
            o_busy    <= 1'b0;
          end else begin
            r_count <= r_count + 1'b1;
          end
        end
        WAIT_OP: begin
          if (i_rx_done) begin
            o_alu_op <= i_rx_data[NB_OP-1:0];
            r_count  <= '0;
            r_state  <= EXEC;
          end else if (w_expired) begin
            o_timeout <= 1'b1;
            r_count   <= '0;
            r_state   <= WAIT_A;
            o_busy    <= 1'b0;
          end else begin
            r_count <= r_count + 1'b1;
          end
        end
        EXEC: begin
          o_tx_data  <= i_alu_result;
          o_tx_start <= 1'b1;
          o_overrun  <= i_rx_done;
          r_state    <= SEND;
        end
        SEND: begin
          o_overrun <= i_rx_done;
          r_state   <= WAIT_TX;
        end
        WAIT_TX: begin
          o_overrun <= i_rx_done;
          if (i_tx_done) begin
            r_state <= WAIT_A;
            o_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= WAIT_A;
          o_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
